iter_fft_core: RTL and testbench

- Sequential, parametrised successor to the combinational recursive FFT.
- Accepts one frame of N complex fixed-point samples over a valid/ready stream and stores them in bit-reversed order.
- Computes an in-place radix-2 DIT FFT or IFFT with one shared butterfly. Direction is selected at run time per frame, not by parameter.
- Streams N results out in natural order over a valid/ready stream. Sits between the sample front-end and spectral post-processing.

---
 rtl/iter_fft_core.sv | 220 ++++++++++++++++++++++
 tb/tb_iter_fft_core.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_fft_core.sv
// In-place radix-2 DIT FFT/IFFT over one shared butterfly; frame in bit-reversed, results out in order, first out_valid log2N*N/2+1 cycles after last input.
// No overlap: in_ready low during COMPUTE/UNLOAD, output held while !out_ready. `IFFT_SCALE_EN halves each inverse butterfly (1/N overall).
module iter_fft_core #(
  parameter int N        = 8,
  parameter int W        = 16,
  parameter int BIT_FRAC = 8,
  parameter int TW_FRAC  = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_re,
  input  logic [W-1:0]         in_im,
  input  logic                 in_last,
  input  logic                 in_inv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W+$clog2(N):0] out_re,
  output logic [W+$clog2(N):0] out_im,
  output logic                 out_last,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int LOGN = $clog2(N);
  localparam int OW   = W + LOGN + 1;
  localparam int TWW  = TW_FRAC + 2;
  localparam int PW   = OW + TWW;
  localparam logic signed [PW:0] RND =
    $signed({{(PW + 1 - TW_FRAC){1'b0}}, 1'b1, {(TW_FRAC - 1){1'b0}}});

  if ((1 << LOGN) != N || N < 4 || N > 1024) begin : g_chk_n
    $error("iter_fft_core: N must be a power of 2 in 4..1024");
  end
  if (BIT_FRAC >= W) begin : g_chk_frac
    $error("iter_fft_core: BIT_FRAC must be smaller than W");
  end

  function automatic int tw_val(input int k, input bit want_sin);
    real ang;
    real v;
    ang = 6.283185307179586 * $itor(k) / $itor(N);
    v   = (want_sin ? $sin(ang) : $cos(ang)) * $itor(1 << TW_FRAC);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] x);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = x[LOGN-1-i];
    return r;
  endfunction

  function automatic logic signed [PW-1:0] mul(input logic signed [OW-1:0] x,
                                               input logic signed [TWW-1:0] w);
    return $signed({{TWW{x[OW-1]}}, x}) * $signed({{OW{w[TWW-1]}}, w});
  endfunction

  function automatic logic signed [PW:0] ext(input logic signed [PW-1:0] p);
    return {p[PW-1], p};
  endfunction

  function automatic logic signed [OW-1:0] tw_round(input logic signed [PW:0] s);
    logic signed [PW:0] r;
    r = s + RND;
    r = r >>> TW_FRAC;
    return r[OW-1:0];
  endfunction

  // Sum/difference kept one bit wider so the optional halving sees the carry.
  function automatic logic signed [OW-1:0] bf_out(input logic signed [OW-1:0] x,
                                                  input logic signed [OW-1:0] y,
                                                  input logic sub,
                                                  input logic scale);
    logic signed [OW:0] s;
    s = sub ? ({x[OW-1], x} - {y[OW-1], y}) : ({x[OW-1], x} + {y[OW-1], y});
    if (scale) begin
      s = s + $signed({{OW{1'b0}}, 1'b1});
      s = s >>> 1;
    end
    return s[OW-1:0];
  endfunction

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
  state_t state, state_nxt;

  logic [LOGN-1:0]       cnt, cnt_inc;
  logic [3:0]            stg;
  logic [LOGN-2:0]       bfly;
  logic                  mode;
  logic                  in_fire, last_bfly, scale;
  logic signed [OW-1:0]  mem_re [N];
  logic signed [OW-1:0]  mem_im [N];
  logic signed [TWW-1:0] rom_cos [N/2];
  logic signed [TWW-1:0] rom_sin [N/2];

  for (genvar g = 0; g < N/2; g++) begin : g_rom
    localparam int C = tw_val(g, 1'b0);
    localparam int S = tw_val(g, 1'b1);
    assign rom_cos[g] = TWW'(C);
    assign rom_sin[g] = TWW'(S);
  end

`ifdef IFFT_SCALE_EN
  assign scale = mode;
`else
  assign scale = 1'b0;
`endif

  logic [LOGN-2:0]       pos, grp, tw_idx;
  logic [LOGN-1:0]       ia, ib;
  logic signed [TWW-1:0] wr, wi;
  logic signed [OW-1:0]  a_re, a_im, b_re, b_im, t_re, t_im;

  // Butterfly b of stage s: group b>>s, offset b mod 2^s, partner 2^s above.
  assign pos    = bfly & (LOGN-1)'((32'd1 << stg) - 32'd1);
  assign grp    = bfly >> stg;
  assign ia     = ({grp, 1'b0} << stg) | {1'b0, pos};
  assign ib     = ia | ({{(LOGN-1){1'b0}}, 1'b1} << stg);
  assign tw_idx = pos << (4'(LOGN - 1) - stg);

  assign wr   = rom_cos[tw_idx];
  assign wi   = mode ? rom_sin[tw_idx] : -rom_sin[tw_idx];
  assign a_re = mem_re[ia];
  assign a_im = mem_im[ia];
  assign b_re = mem_re[ib];
  assign b_im = mem_im[ib];
  assign t_re = tw_round(ext(mul(b_re, wr)) - ext(mul(b_im, wi)));
  assign t_im = tw_round(ext(mul(b_re, wi)) + ext(mul(b_im, wr)));

  assign in_fire   = in_valid && in_ready;
  assign cnt_inc   = cnt + LOGN'(1);
  assign last_bfly = (state == COMPUTE) && (stg == 4'(LOGN - 1)) &&
                     (bfly == (LOGN-1)'(N/2 - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && cnt == LOGN'(N - 1)) state_nxt = COMPUTE;
      end
      COMPUTE: if (last_bfly) state_nxt = UNLOAD;
      UNLOAD:  if (out_valid && out_ready && out_last) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_re[bitrev(cnt)] <= {{(OW-W){in_re[W-1]}}, in_re};
      mem_im[bitrev(cnt)] <= {{(OW-W){in_im[W-1]}}, in_im};
    end else if (state == COMPUTE) begin
      mem_re[ia] <= bf_out(a_re, t_re, 1'b0, scale);
      mem_im[ia] <= bf_out(a_im, t_im, 1'b0, scale);
      mem_re[ib] <= bf_out(a_re, t_re, 1'b1, scale);
      mem_im[ib] <= bf_out(a_im, t_im, 1'b1, scale);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      stg       <= '0;
      bfly      <= '0;
      mode      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= in_fire && (in_last != (cnt == LOGN'(N - 1)));
      case (state)
        LOAD: if (in_fire) begin
          if (cnt == '0) mode <= in_inv;
          cnt <= cnt_inc;  // wraps to 0, ready for UNLOAD
        end
        COMPUTE: begin
          if (last_bfly) begin
            bfly <= '0;
            stg  <= '0;
          end else if (bfly == (LOGN-1)'(N/2 - 1)) begin
            bfly <= '0;
            stg  <= stg + 4'd1;
          end else begin
            bfly <= bfly + (LOGN-1)'(1);
          end
        end
        UNLOAD: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_re    <= mem_re[cnt];
            out_im    <= mem_im[cnt];
            out_last  <= (cnt == LOGN'(N - 1));
          end else if (out_ready) begin
            cnt <= cnt_inc;
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_re   <= mem_re[cnt_inc];
              out_im   <= mem_im[cnt_inc];
              out_last <= (cnt_inc == LOGN'(N - 1));
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_fft_core.sv
// Directed bench for iter_fft_core: N=8 and N=4 instances share the stimulus bus, sel picks the active one.
// Expected results are queued when a frame is sent and popped as the DUT hands results out.
module tb_iter_fft_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_last, in_inv, out_ready, sel;
  logic [15:0] in_re, in_im;
  logic        r8, v8, l8, e8, b8, r4, v4, l4, e4, b4;
  logic [19:0] re8, im8;
  logic [18:0] re4, im4;

  iter_fft_core #(.N(8), .W(16), .BIT_FRAC(8), .TW_FRAC(14)) u_fft8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(r8),
    .in_re(in_re), .in_im(in_im), .in_last(in_last), .in_inv(in_inv),
    .out_valid(v8), .out_ready(out_ready), .out_re(re8), .out_im(im8),
    .out_last(l8), .frame_err(e8), .busy(b8));

  iter_fft_core #(.N(4), .W(16), .BIT_FRAC(8), .TW_FRAC(14)) u_fft4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(r4),
    .in_re(in_re), .in_im(in_im), .in_last(in_last), .in_inv(in_inv),
    .out_valid(v4), .out_ready(out_ready), .out_re(re4), .out_im(im4),
    .out_last(l4), .frame_err(e4), .busy(b4));

  logic               in_rdy, o_vld, o_last, fe, bsy;
  logic signed [19:0] o_re, o_im;
  assign in_rdy = sel ? r4 : r8;
  assign o_vld  = sel ? v4 : v8;
  assign o_last = sel ? l4 : l8;
  assign fe     = sel ? e4 : e8;
  assign bsy    = sel ? b4 : b8;
  assign o_re   = sel ? {re4[18], re4} : re8;
  assign o_im   = sel ? {im4[18], im4} : im8;

  typedef struct packed {
    logic signed [19:0] re;
    logic signed [19:0] im;
    logic               last;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int failures = 0;
  int err_pulses;
  int xr[8];
  int xi[8];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int re, input int im, input logic last);
    exp_t e;
    e.re   = 20'(re);
    e.im   = 20'(im);
    e.last = last;
    sbq.push_back(e);
  endtask

  task automatic send_frame(input int n, input logic inv, input int bad);
    int waitc;
    err_pulses = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_re    = 16'(xr[i]);
      in_im    = 16'(xi[i]);
      in_inv   = inv;
      in_last  = (i == n - 1) || (i == bad);
      waitc    = 0;
      while (!in_rdy && waitc < 100) begin
        tick;
        waitc++;
      end
      if (waitc >= 100) begin
        chk("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      tick;
      if (fe) err_pulses++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input int n, input int stall_k, input int stall_len, input int exp_lat);
    int   waitc;
    exp_t e;
    waitc = 0;
    while (!o_vld && waitc < 200) begin
      tick;
      waitc++;
    end
    if (exp_lat >= 0) chk("latency", waitc, exp_lat);
    for (int k = 0; k < n; k++) begin
      waitc = 0;
      while (!o_vld && waitc < 50) begin
        tick;
        waitc++;
      end
      if (waitc >= 50 || sbq.size() == 0) begin
        chk($sformatf("out_valid_timeout_k%0d", k), 0, 1);
        sbq.delete();
        return;
      end
      e = sbq.pop_front();
      if (k == stall_k) begin
        out_ready = 1'b0;
        repeat (stall_len) begin
          tick;
          chk("stall_valid", o_vld, 1);
          chk("stall_re", o_re, $signed(e.re));
          chk("stall_im", o_im, $signed(e.im));
        end
        out_ready = 1'b1;
      end
      chk($sformatf("re_k%0d", k), o_re, $signed(e.re));
      chk($sformatf("im_k%0d", k), o_im, $signed(e.im));
      chk($sformatf("last_k%0d", k), o_last, e.last);
      tick;
    end
    chk("valid_drop", o_vld, 0);
    chk("ready_back", in_rdy, 1);
    chk("sb_empty", sbq.size(), 0);
  endtask

  task automatic load_dc8;
    for (int i = 0; i < 8; i++) begin
      xr[i] = 256;
      xi[i] = 0;
      push((i == 0) ? 2048 : 0, 0, i == 7);
    end
  endtask

  initial begin
    int vcount;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_inv = 1'b0;
    in_re = '0; in_im = '0; out_ready = 1'b1; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick;
    chk("rst_in_ready", in_rdy, 1);
    chk("rst_out_valid", o_vld, 0);
    chk("rst_out_last", o_last, 0);
    chk("rst_frame_err", fe, 0);
    chk("rst_busy", bsy, 0);
    chk("rst_out_re", o_re, 0);
    chk("rst_out_im", o_im, 0);
    chk("rst_in_ready4", r4, 1);

    // Impulse, N=8
    for (int i = 0; i < 8; i++) begin
      xr[i] = (i == 0) ? 256 : 0;
      xi[i] = 0;
      push(256, 0, i == 7);
    end
    send_frame(8, 1'b0, -1);
    chk("impulse_frame_err", err_pulses, 0);
    chk("compute_busy", bsy, 1);
    chk("compute_in_ready", in_rdy, 0);
    drain(8, -1, 0, 13);

    // DC, N=8, with a spurious in_last on sample 1
    load_dc8();
    send_frame(8, 1'b0, 1);
    chk("dc_frame_err_once", err_pulses, 1);
    drain(8, -1, 0, 13);

    // Ramp, N=4, stalled 5 cycles at k=2
    sel = 1'b1;
    for (int k = 0; k < 4; k++) begin
      xr[k] = k * 256;
      xi[k] = (3 - k) * 256;
    end
    push(1536, 1536, 0);
    push(0, 1024, 0);
    push(-512, 512, 0);
    push(-1024, 0, 1);
    send_frame(4, 1'b0, -1);
    chk("ramp_frame_err", err_pulses, 0);
    drain(4, 2, 5, 5);

    // Round trip: ramp spectrum back through the inverse
    xr[0] = 1536;  xi[0] = 1536;
    xr[1] = 0;     xi[1] = 1024;
    xr[2] = -512;  xi[2] = 512;
    xr[3] = -1024; xi[3] = 0;
    for (int k = 0; k < 4; k++) begin
`ifdef IFFT_SCALE_EN
      push(k * 256, (3 - k) * 256, k == 3);
`else
      push(4 * k * 256, 4 * (3 - k) * 256, k == 3);
`endif
    end
    send_frame(4, 1'b1, -1);
    drain(4, -1, 0, 5);

    // Reset in the middle of COMPUTE
    sel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      xr[i] = (i == 0) ? 256 : 0;
      xi[i] = 0;
    end
    send_frame(8, 1'b0, -1);
    repeat (4) tick;
    chk("pre_reset_busy", bsy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_rdy, 1);
    chk("midrst_busy", bsy, 0);
    chk("midrst_out_valid", o_vld, 0);
    tick;
    rst_n = 1'b1;
    vcount = 0;
    repeat (30) begin
      tick;
      if (o_vld) vcount++;
    end
    chk("midrst_no_output", vcount, 0);

    // Recovery frame
    load_dc8();
    send_frame(8, 1'b0, -1);
    chk("recover_frame_err", err_pulses, 0);
    drain(8, -1, 0, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
